// File: rtl/midi_pkg.sv
// midi_pkg: MIDI status bytes, decoded command types and parser states
package midi_pkg;
  localparam logic [7:0] ST_ON   = 8'h90;
  localparam logic [7:0] ST_OFF  = 8'h80;
  localparam logic [7:0] ST_CC   = 8'hB0;
  localparam logic [7:0] ST_BEND = 8'hE0;
  typedef enum logic [1:0] {T_ON, T_OFF, T_CC, T_BEND} cmd_type_e;
  typedef enum logic [1:0] {IDLE, VOICE, D1, D2} state_e;
  function automatic logic is_status(input logic [7:0] b);
    return b == ST_ON || b == ST_OFF || b == ST_CC || b == ST_BEND;
  endfunction
  function automatic cmd_type_e status_type(input logic [7:0] b);
    return b == ST_OFF ? T_OFF : b == ST_CC ? T_CC : b == ST_BEND ? T_BEND : T_ON;
  endfunction
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous show-ahead FIFO with wrap-bit pointers
module cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic wr, rd;
  always_comb begin
    empty = wp_q == rp_q;
    full  = (wp_q ^ rp_q) == {1'b1, {AW{1'b0}}};
    rd    = pop && !empty;
    wr    = push && (!full || rd);
    wp_d  = wr ? wp_q + 1'b1 : wp_q;
    rp_d  = rd ? rp_q + 1'b1 : rp_q;
    dout  = mem[rp_q[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wp_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/midi_cmd_decoder.sv
// midi_cmd_decoder: synchronises SPI byte strobes and parses MIDI commands into a FIFO
module midi_cmd_decoder
  import midi_pkg::*;
#(
  parameter int NUM_VOICES     = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000,
  localparam int VOICE_W       = NUM_VOICES > 1 ? $clog2(NUM_VOICES) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_done,
  input  logic [7:0]         rx_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_type,
  output logic [VOICE_W-1:0] out_voice,
  output logic [6:0]         out_key,
  output logic [13:0]        out_value,
  output logic               busy,
  output logic [7:0]         err_count,
  output logic [7:0]         ovf_count
);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WIDTH = 2 + VOICE_W + 21;
  logic s1_q, s2_q, prev_q, edge_q, edge_d;
  logic [7:0] byte_q, byte_d, err_q, err_d, ovf_q, ovf_d;
  state_e state_q, state_d;
  cmd_type_e type_q, type_d;
  logic [VOICE_W-1:0] voice_q, voice_d;
  logic [6:0] d1_q, d1_d, key;
  logic [13:0] value;
  logic [TO_W-1:0] to_q, to_d;
  logic push, err_inc, known, full, empty;
  logic [WIDTH-1:0] dout;
  always_comb begin
    edge_d  = s2_q & ~prev_q;
    byte_d  = edge_d ? rx_data : byte_q;
    state_d = state_q;
    type_d  = type_q;
    voice_d = voice_q;
    d1_d    = d1_q;
    push    = 1'b0;
    err_inc = 1'b0;
    known   = is_status(byte_q);
    if (edge_q) begin
      if (state_q == IDLE) begin
        if (known) begin
          type_d  = status_type(byte_q);
          state_d = VOICE;
        end
      end else if (byte_q[7]) begin
        err_inc = 1'b1;
        state_d = known ? VOICE : IDLE;
        if (known) type_d = status_type(byte_q);
      end else begin
        case (state_q)
          VOICE: begin
            if (32'(byte_q) < NUM_VOICES) begin
              voice_d = VOICE_W'(byte_q);
              push    = type_q == T_OFF;
              state_d = type_q == T_OFF ? IDLE : D1;
            end else begin
              err_inc = 1'b1;
              state_d = IDLE;
            end
          end
          D1: begin
            d1_d    = byte_q[6:0];
            state_d = D2;
          end
          D2: begin
            push    = 1'b1;
            state_d = IDLE;
          end
          default: ;
        endcase
      end
    end else if (state_q != IDLE && to_q == TO_W'(TIMEOUT_CYCLES)) begin
      err_inc = 1'b1;
      state_d = IDLE;
    end
    to_d  = (edge_q || state_q == IDLE) ? '0 : to_q + 1'b1;
    key   = (type_q == T_ON || type_q == T_CC) ? d1_q : 7'd0;
    value = type_q == T_BEND ? {byte_q[6:0], d1_q} : type_q == T_OFF ? 14'd0 : {7'd0, byte_q[6:0]};
    err_d = err_q + {7'd0, err_inc && err_q != 8'hFF};
    ovf_d = ovf_q + {7'd0, push && full && !(out_ready && out_valid) && ovf_q != 8'hFF};
  end
  // Synchroniser and edge history reset high so a level already high at release is not an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      prev_q  <= 1'b1;
      edge_q  <= 1'b0;
      byte_q  <= '0;
      state_q <= IDLE;
      type_q  <= T_ON;
      voice_q <= '0;
      d1_q    <= '0;
      to_q    <= '0;
      err_q   <= '0;
      ovf_q   <= '0;
    end else begin
      s1_q    <= rx_done;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      edge_q  <= edge_d;
      byte_q  <= byte_d;
      state_q <= state_d;
      type_q  <= type_d;
      voice_q <= voice_d;
      d1_q    <= d1_d;
      to_q    <= to_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
    end
  end
  cmd_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .din({type_q, voice_d, key, value}),
    .pop(out_ready), .dout(dout), .full(full), .empty(empty)
  );
  always_comb begin
    out_valid = !empty;
    out_type  = out_valid ? dout[WIDTH-1 -: 2] : 2'd0;
    out_voice = out_valid ? dout[21 +: VOICE_W] : '0;
    out_key   = out_valid ? dout[14 +: 7] : 7'd0;
    out_value = out_valid ? dout[13:0] : 14'd0;
    busy      = state_q != IDLE;
    err_count = err_q;
    ovf_count = ovf_q;
  end
endmodule

// File: doc/midi_cmd_decoder.md
# midi_cmd_decoder

Parametrised MIDI command decoder sitting between the SPI byte receiver (`spi_slave`) and the voice allocator/synth core. It synchronises the receiver's byte-done strobe into `clk`, parses NOTE ON, NOTE OFF, CONTROL CHANGE and PITCH BEND commands of configurable voice count, and queues decoded commands in an output FIFO with a valid/ready handshake. Over the single-command register interface it adds:

- resynchronisation on a stray status byte;
- a mid-command timeout;
- voice-range checking;
- saturating error and overflow counters.

## Interface
- `NUM_VOICES`, 16 — voices addressable; `VOICE_W = max(1, $clog2(NUM_VOICES))`
- `FIFO_DEPTH`, 4 — decoded-command queue depth, power of 2, ≥ 2
- `TIMEOUT_CYCLES`, 50000 — idle `clk` cycles allowed between bytes of one command, ≥ 2
- `clk` in 1 — system clock
- `reset` in 1 — synchronous, active-high
- `rx_done` in 1 — byte-done level from `spi_slave`, asynchronous to `clk`
- `rx_data` in 8 — received byte, stable while `rx_done` high
- `out_valid` out 1 — FIFO head holds a command
- `out_ready` in 1 — consumer accepts head this cycle
- `out_type` out 2 — 0 NOTE_ON, 1 NOTE_OFF, 2 CC, 3 BEND
- `out_voice` out VOICE_W — voice index
- `out_key` out 7 — note (NOTE_ON), controller number (CC), else 0
- `out_value` out 14 — velocity (NOTE_ON) or CC value, zero-extended; {msb,lsb} (BEND); 0 (NOTE_OFF)
- `busy` out 1 — parser is mid-command
- `err_count` out 8 — saturating count of aborted/rejected commands
- `ovf_count` out 8 — saturating count of commands dropped on full FIFO

## Operation
- **Byte strobe:** `rx_done` → 2-flop synchroniser → rising-edge detect. Each edge is one byte event. `rx_data` is sampled on the edge-detect cycle.
- **Status bytes:** 0x90 ON (3 payload bytes: voice, note, velocity), 0x80 OFF (1: voice), 0xB0 CC (3: voice, ctrl, value), 0xE0 BEND (3: voice, lsb, msb). Low nibble must be 0; any other byte with bit 7 set is "unknown".
- **States:** `IDLE`, `VOICE`, `D1`, `D2`.
  - `IDLE`: known status → latch type, go `VOICE`. Unknown status or data byte → ignored, no count.
  - `VOICE`: byte < NUM_VOICES → latch; go `D1`, or push (OFF) and go `IDLE`. Otherwise see rejection rules below.
  - `D1` → `D2` → push, `IDLE`.
- **Rejection:**
  - Voice byte ≥ NUM_VOICES: `err_count`+1 and go `IDLE`. Payload bytes that follow are then ignored as stray data.
  - Bit 7 set on a payload byte (`VOICE`/`D1`/`D2`): `err_count`+1. If it is a known status, restart parse with it and go `VOICE`; else go `IDLE`.
- **Timeout:** timeout counter resets on every byte event. If it reaches TIMEOUT_CYCLES while not `IDLE`: `err_count`+1, go `IDLE`.
- **Push:** a push when the FIFO is full drops the command and does `ovf_count`+1, unless `out_ready && out_valid` in the same cycle, in which case pop and push both occur.
- `busy` = state ≠ `IDLE`.
- **Counters** saturate at 255.
- **Reset mid-command:** partial command discarded; FIFO flushed; synchroniser cleared. A level-high `rx_done` at reset release is not counted as an edge, because the edge detector's previous-sample flop resets to 1.

## Timing
- **Reset values:** `out_valid`=0, `out_type`/`out_voice`/`out_key`/`out_value`=0, `busy`=0, `err_count`=0, `ovf_count`=0, state `IDLE`.
- **Latency:** `rx_done` first sampled high at cycle N → edge at N+2 → final-byte push registered at N+3 → `out_valid` high at N+3 if the FIFO was empty (show-ahead head).
- **Handshake:** head is presented while `out_valid`; it advances on `out_valid && out_ready`. Outputs hold while `out_ready`=0. `out_ready` with `out_valid`=0 has no effect.
- **Throughput:** one byte event per 3 `clk` minimum. `rx_done` must stay high ≥ 2 `clk` and low ≥ 2 `clk`.

## Structure
- **`midi_pkg`:** status constants (0x90/0x80/0xB0/0xE0), the `out_type` encodings, and the parser state enum.
- **Sub-module `cmd_fifo`:** synchronous show-ahead FIFO, parameters WIDTH and DEPTH. Pointers one bit wider than the address, for full/empty detection. Word = {type, voice, key, value}.
- Synchroniser, edge detect, parser FSM and timeout counter live in the top.

## Test plan
- **NOTE ON:** bytes 0x90,0x03,0x3C,0x64, `out_ready`=1 → one command: type 0, voice 3, key 0x3C, value 100, `out_valid` at N+3 of last byte.
- **NOTE OFF + BEND:** bytes 0x80,0x05 then 0xE0,0x01,0x7F,0x40 → OFF voice 5 key 0 value 0; then BEND voice 1 value 0x207F.
- **Resync:** bytes 0x90,0x02,0x3C,0xB0,0x04,0x07,0x7F → `err_count`=1, single CC voice 4 key 7 value 127.
- **Voice range and timeout:** NUM_VOICES=16. Send 0x90,0x10,0x3C,0x64 → `err_count`=1, no push. Send 0x90,0x01 then idle TIMEOUT_CYCLES → `err_count`=2, `busy` low.
- **Overflow:** FIFO_DEPTH=4, `out_ready`=0, 6 NOTE OFFs → 4 queued, `ovf_count`=2. Then pop all → original first 4 order.
- **Reset mid-command:** assert `reset` after 0x90,0x01 with 2 commands queued → `out_valid`=0, counters 0. The next full command decodes normally.
